stopwatch_control: RTL

//   Run-control stage directly upstream of CounterModule: turns debounced start/stop, lap, clear

---
 rtl/stopwatch_control.sv | 138 +++++++++++++
 1 files changed

// File: rtl/stopwatch_control.sv
// rtl/stopwatch_control.sv - run-control FSM, tick divider and lap freeze ahead of the BCD counter
// Optional lap feature: define STOPWATCH_LAP_EN to build the LAP state, lap_reg and btn_lap handling.
module stopwatch_control #(
   parameter int WIDTH   = 16,
   parameter int CLK_HZ  = 100_000_000,
   parameter int TICK_HZ = 100
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btn_start_stop,
   input  logic             btn_lap,
   input  logic             btn_clear,
   input  logic [WIDTH-1:0] count_value,
   output logic             count_enable,
   output logic             count_clear,
   output logic [WIDTH-1:0] display_value,
   output logic             running,
   output logic             lap_active
);
   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int DW  = $clog2(DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_LAP   = 2'd3
   } state_t;

   state_t        state;
   state_t        nxt_state;
   logic          ss_q;
   logic          clr_q;
   logic          ss_p;
   logic          clr_p;
   logic          lap_go;
   logic          do_clear;
   logic          cap_lap;
   logic          is_running;
   logic          nxt_running;
   logic [DW-1:0] divider;

`ifdef STOPWATCH_LAP_EN
   logic             lap_q;
   logic             lap_p;
   logic [WIDTH-1:0] lap_reg;
   assign lap_go = lap_p;
`else
   logic unused_lap;
   assign unused_lap = btn_lap;
   assign lap_go     = 1'b0;
   assign lap_active = 1'b0;
`endif

   assign is_running  = (state == ST_RUN) || (state == ST_LAP);
   assign nxt_running = (nxt_state == ST_RUN) || (nxt_state == ST_LAP);

   // Presses are registered one stage before the FSM; clear outranks start_stop, which outranks lap.
   always_comb begin
      nxt_state = state;
      do_clear  = 1'b0;
      cap_lap   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (clr_p)     do_clear  = 1'b1;
            else if (ss_p) nxt_state = ST_RUN;
         end
         ST_RUN: begin
            if (ss_p) nxt_state = ST_PAUSE;
            else if (lap_go) begin
               nxt_state = ST_LAP;
               cap_lap   = 1'b1;
            end
         end
         ST_LAP: begin
            if (ss_p)        nxt_state = ST_PAUSE;
            else if (lap_go) nxt_state = ST_RUN;
         end
         ST_PAUSE: begin
            if (clr_p) begin
               nxt_state = ST_IDLE;
               do_clear  = 1'b1;
            end else if (ss_p) nxt_state = ST_RUN;
         end
         default: nxt_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ss_q          <= 1'b1;
         clr_q         <= 1'b1;
         ss_p          <= 1'b0;
         clr_p         <= 1'b0;
         state         <= ST_IDLE;
         divider       <= '0;
         count_enable  <= 1'b0;
         count_clear   <= 1'b0;
         running       <= 1'b0;
         display_value <= '0;
`ifdef STOPWATCH_LAP_EN
         lap_q         <= 1'b1;
         lap_p         <= 1'b0;
         lap_reg       <= '0;
         lap_active    <= 1'b0;
`endif
      end else begin
         ss_q         <= btn_start_stop;
         clr_q        <= btn_clear;
         ss_p         <= btn_start_stop & ~ss_q;
         clr_p        <= btn_clear & ~clr_q;
         state        <= nxt_state;
         running      <= nxt_running;
         count_enable <= is_running && (divider == DIV_LAST);
         count_clear  <= do_clear;
         // PAUSE keeps the partial tick so a resume finishes the interrupted period.
         if (is_running)
            divider <= (divider == DIV_LAST) ? '0 : divider + 1'b1;
         else if (state == ST_IDLE)
            divider <= '0;
`ifdef STOPWATCH_LAP_EN
         lap_q      <= btn_lap;
         lap_p      <= btn_lap & ~lap_q;
         lap_active <= (nxt_state == ST_LAP);
         if (cap_lap)
            lap_reg <= count_value;
         if (nxt_state == ST_LAP)
            display_value <= cap_lap ? count_value : lap_reg;
         else
            display_value <= count_value;
`else
         display_value <= count_value;
`endif
      end
   end

endmodule
